// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM states and
// fixed instruction/PC-step constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

endpackage

// File: rtl/fetch_pc_reg.sv
// N-bit program counter register with synchronous reset to zero and a
// load enable selecting the supplied next value.
module fetch_pc_reg #(
  parameter int N = 64
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [N-1:0] pc_d_i,
  output logic [N-1:0] pc_q_o
);

  logic [N-1:0] pc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= '0;
    end else if (load_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_q_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request at a time,
// stall-aware delivery, and redirects that discard in-flight responses.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int N  = 64,
  parameter int IW = INSTR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          branch_F,
  input  logic [N-1:0]  branch_target_F,
  input  logic          stall_F,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  output logic          instr_valid_F,
  output logic [IW-1:0] instr_F,
  output logic [N-1:0]  pc_F
);

  fetch_state_e  state_q, state_d;
  logic          drop_q, drop_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [N-1:0]  pcf_q, pcf_d;
  logic          pc_load;
  logic [N-1:0]  pc_next;
  logic [N-1:0]  pc;

  fetch_pc_reg #(.N(N)) u_pc_reg (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (pc_load),
    .pc_d_i  (pc_next),
    .pc_q_o  (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      pcf_q   <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pcf_q   <= pcf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    valid_d = 1'b0;
    instr_d = instr_q;
    pcf_d   = pcf_q;
    pc_load = 1'b0;
    pc_next = pc;

    if (branch_F) begin
      pc_load = 1'b1;
      pc_next = branch_target_F;
      state_d = REQ;
      drop_d  = 1'b0;
      // A request already accepted by memory must still be drained before reissuing.
      if ((state_q == REQ && imem_gnt) || (state_q == WAIT && !imem_rvalid)) begin
        state_d = WAIT;
        drop_d  = 1'b1;
      end
    end else begin
      case (state_q)
        REQ: begin
          if (imem_gnt) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = REQ;
            end else begin
              instr_d = imem_rdata;
              pcf_d   = pc;
              valid_d = 1'b1;
              pc_load = 1'b1;
              pc_next = pc + N'(PC_INC);
              state_d = stall_F ? HOLD : REQ;
            end
          end
        end
        HOLD: begin
          valid_d = stall_F ? valid_q : 1'b0;
          if (!stall_F) state_d = REQ;
        end
        default: state_d = REQ;
      endcase
    end
  end

  assign imem_req      = (state_q == REQ);
  assign imem_addr     = pc;
  assign instr_valid_F = valid_q;
  assign instr_F       = instr_q;
  assign pc_F          = pcf_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a transaction-level model of the fetch
// contract is checked every cycle, plus hand-computed spot values.
module tb_fetch_ctrl;

  localparam int N  = 64;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          branch_F = 1'b0;
  logic [N-1:0]  branch_target_F = '0;
  logic          stall_F = 1'b0;
  logic          imem_req;
  logic [N-1:0]  imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          instr_valid_F;
  logic [IW-1:0] instr_F;
  logic [N-1:0]  pc_F;

  int checks = 0;
  int passed = 0;

  // model state: outstanding request, pending discard, parked instruction
  logic [N-1:0]  m_pc = '0;
  logic          m_out = 1'b0;
  logic          m_drop = 1'b0;
  logic          m_hold = 1'b0;
  logic          m_valid = 1'b0;
  logic [IW-1:0] m_instr = '0;
  logic [N-1:0]  m_pcf = '0;

  fetch_ctrl #(.N(N), .IW(IW)) dut (
    .clk             (clk),
    .reset           (reset),
    .branch_F        (branch_F),
    .branch_target_F (branch_target_F),
    .stall_F         (stall_F),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid_F   (instr_valid_F),
    .instr_F         (instr_F),
    .pc_F            (pc_F)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic m_req();
    return !m_out && !m_hold;
  endfunction

  task automatic compare_model();
    chk("imem_req", 64'(imem_req), 64'(m_req()));
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid_F", 64'(instr_valid_F), 64'(m_valid));
    chk("instr_F", 64'(instr_F), 64'(m_instr));
    chk("pc_F", pc_F, m_pcf);
  endtask

  task automatic model_update();
    logic req_now;
    req_now = m_req();
    if (reset) begin
      m_pc = '0; m_out = 0; m_drop = 0; m_hold = 0;
      m_valid = 0; m_instr = '0; m_pcf = '0;
    end else if (branch_F) begin
      m_pc    = branch_target_F;
      m_valid = 0;
      m_hold  = 0;
      if ((m_out && !imem_rvalid) || (req_now && imem_gnt)) begin
        m_out = 1; m_drop = 1;
      end else begin
        m_out = 0; m_drop = 0;
      end
    end else if (m_out && imem_rvalid) begin
      m_out = 0;
      if (m_drop) begin
        m_drop = 0;
      end else begin
        m_instr = imem_rdata;
        m_pcf   = m_pc;
        m_pc    = m_pc + 64'd4;
        m_valid = 1;
        m_hold  = stall_F;
      end
    end else if (req_now && imem_gnt) begin
      m_out = 1; m_valid = 0;
    end else if (m_hold) begin
      if (!stall_F) begin
        m_hold = 0; m_valid = 0;
      end
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic step(input logic g, input logic rv, input logic [IW-1:0] rd,
                      input logic st, input logic br, input logic [N-1:0] tgt);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    stall_F = st; branch_F = br; branch_target_F = tgt;
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 64'(instr_valid_F), 64'd0);
    chk("rst pc_F", pc_F, 64'd0);
    chk("rst instr_F", 64'(instr_F), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("post-rst req", 64'(imem_req), 64'd1);
    chk("post-rst addr", imem_addr, 64'd0);

    // back-to-back delivery
    step(1, 0, 0, 0, 0, 0);
    chk("wait no req", 64'(imem_req), 64'd0);
    step(0, 1, 32'hA0, 0, 0, 0);
    chk("d0 valid", 64'(instr_valid_F), 64'd1);
    chk("d0 pc_F", pc_F, 64'd0);
    chk("d0 instr", 64'(instr_F), 64'hA0);
    chk("d0 next addr", imem_addr, 64'd4);
    step(1, 0, 0, 0, 0, 0);
    chk("pulse ends", 64'(instr_valid_F), 64'd0);
    step(0, 1, 32'hA1, 0, 0, 0);
    chk("d1 pc_F", pc_F, 64'd4);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hA2, 1, 0, 0);
    chk("d2 pc_F", pc_F, 64'd8);
    chk("d2 valid", 64'(instr_valid_F), 64'd1);
    chk("d2 no req", 64'(imem_req), 64'd0);

    // held while stalled; gnt and rvalid in HOLD are ignored
    step(1, 0, 0, 1, 0, 0);
    chk("hold pc_F a", pc_F, 64'd8);
    step(0, 1, 32'hDEAD, 1, 0, 0);
    chk("hold instr", 64'(instr_F), 64'hA2);
    step(0, 0, 0, 1, 0, 0);
    chk("hold req", 64'(imem_req), 64'd0);
    chk("hold valid", 64'(instr_valid_F), 64'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("unstall req", 64'(imem_req), 64'd1);
    chk("unstall addr", imem_addr, 64'd12);
    chk("unstall valid", 64'(instr_valid_F), 64'd0);

    // redirect while waiting: response dropped, new PC after it returns
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hA3, 0, 0, 0);
    chk("d3 pc_F", pc_F, 64'd12);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 64'h100);
    chk("drop no req", 64'(imem_req), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("drop still waits", 64'(imem_req), 64'd0);
    step(0, 1, 32'hBAD, 0, 0, 0);
    chk("dropped valid", 64'(instr_valid_F), 64'd0);
    chk("redirect addr", imem_addr, 64'h100);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hB0, 0, 0, 0);
    chk("tgt pc_F", pc_F, 64'h100);
    chk("tgt instr", 64'(instr_F), 64'hB0);

    // redirect coincident with rvalid and stall
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hC0, 1, 1, 64'h200);
    chk("br+rv valid", 64'(instr_valid_F), 64'd0);
    chk("br+rv pc_F kept", pc_F, 64'h100);
    chk("br+rv addr", imem_addr, 64'h200);
    chk("br+rv req", 64'(imem_req), 64'd1);

    // redirect coincident with grant, then redirect in plain REQ
    step(1, 0, 0, 0, 1, 64'h300);
    chk("br+gnt no req", 64'(imem_req), 64'd0);
    step(0, 1, 32'hBAD, 0, 0, 0);
    chk("br+gnt addr", imem_addr, 64'h300);
    chk("br+gnt valid", 64'(instr_valid_F), 64'd0);
    step(0, 0, 0, 0, 1, 64'h400);
    chk("br req addr", imem_addr, 64'h400);

    // PC wrap
    step(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hD0, 0, 0, 0);
    chk("wrap pc_F", pc_F, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap addr", imem_addr, 64'd0);

    // redirect out of HOLD
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hE0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 64'h500);
    chk("hold br valid", 64'(instr_valid_F), 64'd0);
    chk("hold br addr", imem_addr, 64'h500);

    // no grant: request stable
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("nogrant req", 64'(imem_req), 64'd1);
      chk("nogrant addr", imem_addr, 64'h500);
    end

    // reset in WAIT, stale response afterwards is ignored
    step(1, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("rst2 req", 64'(imem_req), 64'd1);
    chk("rst2 addr", imem_addr, 64'd0);
    chk("rst2 instr", 64'(instr_F), 64'd0);
    chk("rst2 valid", 64'(instr_valid_F), 64'd0);
    step(0, 1, 32'hBAD, 0, 0, 0);
    chk("stale ignored", 64'(instr_valid_F), 64'd0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hF0, 0, 0, 0);
    chk("rst2 d pc_F", pc_F, 64'd0);
    chk("rst2 d instr", 64'(instr_F), 64'hF0);
    chk("rst2 d addr", imem_addr, 64'd4);
    step(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
